cache_stats_ctr: RTL and testbench

- Clocked, parametrised statistics unit for the cache model.
- Accumulates per-channel read/write/hit/miss event strobes (channel 0 = instruction cache, channel 1 = data cache by default).
- On a print request it snapshots all channels, sums them, and computes the hit ratio in permille with a sequential divider.
- Returns the results through a busy/valid handshake and displays them at valid.

---
 rtl/cache_stats_pkg.sv | 36 +++
 rtl/stats_seq_div.sv | 78 +++++++
 rtl/cache_stats_ctr.sv | 186 ++++++++++++++++++
 tb/tb_cache_stats_ctr.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared types and constants for the cache statistics unit.
//   stats_state_e  : report sequencer states
//   cache_ev_t     : one channel's event strobes {rd, wr, hit, miss}
//   EV_*           : bit positions of each event inside cache_ev_t
//   CH_INS/CH_DATA : default channel assignment (I-cache, D-cache)
package cache_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SUM,
    ST_DIV,
    ST_DONE
  } stats_state_e;

  localparam int PERMILLE_SCALE = 1000;
  localparam int PM_W           = 11;

  localparam int CH_INS  = 0;
  localparam int CH_DATA = 1;

  typedef struct packed {
    logic rd;
    logic wr;
    logic hit;
    logic miss;
  } cache_ev_t;

  // Packed order puts rd in the MSB.
  localparam int NUM_EV  = 4;
  localparam int EV_RD   = 3;
  localparam int EV_WR   = 2;
  localparam int EV_HIT  = 1;
  localparam int EV_MISS = 0;

endpackage

// File: rtl/stats_seq_div.sv
// Restoring divider, one quotient bit per clock.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : load dividend/divisor and begin N iterations
//   dividend_i    : N-bit dividend
//   divisor_i     : N-bit divisor
//   quotient_o    : quotient, final once done_o is high
//   done_o        : high when no iterations remain
//   dbz_o         : divisor was zero at start (quotient meaningless)
module stats_seq_div #(
  parameter int N = 43
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] quotient_o,
  output logic         done_o,
  output logic         dbz_o
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    rem_sh;

  // The dividend shifts out of the top of quo_q into the remainder while
  // quotient bits shift in at the bottom.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    dbz_d  = dbz_q;
    rem_sh = {rem_q, quo_q[N-1]};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CW'(N);
      dbz_d = (divisor_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sh[N-1:0] - dvs_q;
        quo_d = {quo_q[N-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = (cnt_q == '0);
  assign dbz_o      = dbz_q;

endmodule

// File: rtl/cache_stats_ctr.sv
// Per-channel cache event counters with a snapshot/sum/divide report path.
//   clk, rst_n                 : clock, synchronous active-low reset
//   rd_ev/wr_ev/hit_ev/miss_ev : per-channel event strobes
//   clear                      : zero live counters and ovf
//   print_req                  : snapshot counters and start a report
//   busy, stats_valid          : report in progress / one-cycle result pulse
//   tot_*, hit_permille        : last report's totals and hit ratio
//   ovf                        : sticky, a live counter saturated
//
// state | meaning
// IDLE  | waiting for print_req; snapshot taken on the accepting edge
// SNAP  | sum snapshot channels into totals
// SUM   | load divider with hits*1000 / (reads+writes)
// DIV   | divider iterating, SUM_W+10 cycles
// DONE  | register totals and ratio, pulse stats_valid next edge
module cache_stats_ctr
  import cache_stats_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int SUM_W  = CNT_W + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] rd_ev,
  input  logic [NUM_CH-1:0] wr_ev,
  input  logic [NUM_CH-1:0] hit_ev,
  input  logic [NUM_CH-1:0] miss_ev,
  input  logic              clear,
  input  logic              print_req,
  output logic              busy,
  output logic              stats_valid,
  output logic [SUM_W-1:0]  tot_hits,
  output logic [SUM_W-1:0]  tot_misses,
  output logic [SUM_W-1:0]  tot_reads,
  output logic [SUM_W-1:0]  tot_writes,
  output logic [PM_W-1:0]   hit_permille,
  output logic              ovf
);

  localparam int DIV_W = SUM_W + 10;
  localparam int TMR_W = $clog2(DIV_W + 1);

  cache_ev_t        ev [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH][NUM_EV];
  logic [CNT_W-1:0] cnt_d  [NUM_CH][NUM_EV];
  logic [CNT_W-1:0] snap_q [NUM_CH][NUM_EV];
  logic [SUM_W-1:0] sum_q  [NUM_EV];
  logic [SUM_W-1:0] sum_d  [NUM_EV];
  logic             ovf_q, ovf_d;

  stats_state_e     state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             busy_q, valid_q;
  logic [SUM_W-1:0] tot_hits_q, tot_misses_q, tot_reads_q, tot_writes_q;
  logic [PM_W-1:0]  pm_q;

  logic [SUM_W:0]   den;
  logic [DIV_W-1:0] num, div_dvs, div_quo;
  logic             div_start, div_done, div_dbz;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ev[c] = '{rd: rd_ev[c], wr: wr_ev[c], hit: hit_ev[c], miss: miss_ev[c]};
    end
  end

  // Saturating live counters; a strobe on an all-ones counter flags ovf.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_EV; k++)
          cnt_d[c][k] = '0;
      ovf_d = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_EV; k++)
          if (ev[c][k]) begin
            if (cnt_q[c][k] == {CNT_W{1'b1}}) ovf_d = 1'b1;
            else cnt_d[c][k] = cnt_q[c][k] + 1'b1;
          end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_EV; k++)
          cnt_q[c][k] <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_EV; k++) begin
      sum_d[k] = '0;
      for (int c = 0; c < NUM_CH; c++)
        sum_d[k] = sum_d[k] + SUM_W'(snap_q[c][k]);
    end
  end

  assign den       = {1'b0, sum_q[EV_RD]} + {1'b0, sum_q[EV_WR]};
  assign num       = DIV_W'(sum_q[EV_HIT]) * DIV_W'(PERMILLE_SCALE);
  assign div_dvs   = DIV_W'(den);
  assign div_start = (state_q == ST_SUM);

  stats_seq_div #(.N(DIV_W)) u_div (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (div_start),
    .dividend_i (num),
    .divisor_i  (div_dvs),
    .quotient_o (div_quo),
    .done_o     (div_done),
    .dbz_o      (div_dbz)
  );

  // DIV length is fixed by tmr_q regardless of operands, so a zero
  // denominator costs the same latency as any other report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      tot_hits_q   <= '0;
      tot_misses_q <= '0;
      tot_reads_q  <= '0;
      tot_writes_q <= '0;
      pm_q         <= '0;
      for (int k = 0; k < NUM_EV; k++) sum_q[k] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_EV; k++)
          snap_q[c][k] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (print_req) begin
            snap_q  <= cnt_q;
            busy_q  <= 1'b1;
            state_q <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          sum_q   <= sum_d;
          state_q <= ST_SUM;
        end
        ST_SUM: begin
          tmr_q   <= TMR_W'(DIV_W - 1);
          state_q <= ST_DIV;
        end
        ST_DIV: begin
          if (tmr_q == '0) state_q <= ST_DONE;
          else tmr_q <= tmr_q - 1'b1;
        end
        ST_DONE: begin
          tot_hits_q   <= sum_q[EV_HIT];
          tot_misses_q <= sum_q[EV_MISS];
          tot_reads_q  <= sum_q[EV_RD];
          tot_writes_q <= sum_q[EV_WR];
          pm_q         <= (div_dbz || !div_done) ? '0 : PM_W'(div_quo);
          valid_q      <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign stats_valid  = valid_q;
  assign tot_hits     = tot_hits_q;
  assign tot_misses   = tot_misses_q;
  assign tot_reads    = tot_reads_q;
  assign tot_writes   = tot_writes_q;
  assign hit_permille = pm_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_cache_stats_ctr.sv
// Scoreboard bench for cache_stats_ctr: a default instance (2 ch, 32-bit)
// and a small instance (4 ch, 4-bit) sharing clock and reset.
module tb_cache_stats_ctr;
  import cache_stats_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic [1:0]  a_rd = '0, a_wr = '0, a_hit = '0, a_miss = '0;
  logic        a_clr = 1'b0, a_preq = 1'b0;
  logic        a_busy, a_valid, a_ovf;
  logic [32:0] a_th, a_tm, a_tr, a_tw;
  logic [10:0] a_pm;

  logic [3:0]  b_rd = '0, b_wr = '0, b_hit = '0, b_miss = '0;
  logic        b_clr = 1'b0, b_preq = 1'b0;
  logic        b_busy, b_valid, b_ovf;
  logic [5:0]  b_th, b_tm, b_tr, b_tw;
  logic [10:0] b_pm;

  cache_stats_ctr u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_ev(a_rd), .wr_ev(a_wr), .hit_ev(a_hit),
    .miss_ev(a_miss), .clear(a_clr), .print_req(a_preq), .busy(a_busy),
    .stats_valid(a_valid), .tot_hits(a_th), .tot_misses(a_tm),
    .tot_reads(a_tr), .tot_writes(a_tw), .hit_permille(a_pm), .ovf(a_ovf));

  cache_stats_ctr #(.NUM_CH(4), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_ev(b_rd), .wr_ev(b_wr), .hit_ev(b_hit),
    .miss_ev(b_miss), .clear(b_clr), .print_req(b_preq), .busy(b_busy),
    .stats_valid(b_valid), .tot_hits(b_th), .tot_misses(b_tm),
    .tot_reads(b_tr), .tot_writes(b_tw), .hit_permille(b_pm), .ovf(b_ovf));

  typedef struct {
    int              due;
    longint unsigned h, m, r, w;
    longint unsigned pm;
  } rep_t;

  rep_t exp0[$];
  rep_t exp1[$];

  int              vec = 0, errs = 0, cyc = 0;
  bit              mon_en = 0;
  // model state, event index 0=rd 1=wr 2=hit 3=miss
  longint unsigned mcnt [2][4][4];
  longint unsigned mmax [2];
  bit              movf [2];
  int              nch  [2];
  int              lat  [2];
  int              bs   [2];
  longint unsigned lh [2], lm [2], lr [2], lw [2], lpm [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset(input int i);
    for (int c = 0; c < 4; c++) for (int t = 0; t < 4; t++) mcnt[i][c][t] = 0;
    movf[i] = 0;
    bs[i]   = -1;
    lh[i] = 0; lm[i] = 0; lr[i] = 0; lw[i] = 0; lpm[i] = 0;
    if (i == 0) exp0.delete(); else exp1.delete();
  endfunction

  function automatic void model_edge(input int i, input logic [3:0] rd, wr, hit, miss,
                                     input logic clr, preq, rstn);
    logic [3:0] s[4];
    rep_t e;
    longint unsigned den;
    s[0] = rd; s[1] = wr; s[2] = hit; s[3] = miss;
    if (!rstn) begin
      model_reset(i);
      return;
    end
    if (preq && (bs[i] < 0 || cyc > bs[i] + lat[i])) begin
      e.due = cyc + lat[i];
      e.r = 0; e.w = 0; e.h = 0; e.m = 0;
      for (int c = 0; c < nch[i]; c++) begin
        e.r += mcnt[i][c][0]; e.w += mcnt[i][c][1];
        e.h += mcnt[i][c][2]; e.m += mcnt[i][c][3];
      end
      den  = e.r + e.w;
      e.pm = (den == 0) ? 0 : ((e.h * 1000) / den) % 2048;
      if (i == 0) exp0.push_back(e); else exp1.push_back(e);
      bs[i] = cyc;
    end
    if (clr) begin
      for (int c = 0; c < 4; c++) for (int t = 0; t < 4; t++) mcnt[i][c][t] = 0;
      movf[i] = 0;
    end else begin
      for (int c = 0; c < nch[i]; c++)
        for (int t = 0; t < 4; t++)
          if (s[t][c]) begin
            if (mcnt[i][c][t] == mmax[i]) movf[i] = 1;
            else mcnt[i][c][t]++;
          end
    end
  endfunction

  task automatic step(input int inst, input logic [3:0] rd, wr, hit, miss,
                      input logic clr, preq, rstn);
    @(negedge clk);
    rst_n  = rstn;
    a_rd   = (inst == 0) ? rd[1:0] : 2'b0;
    a_wr   = (inst == 0) ? wr[1:0] : 2'b0;
    a_hit  = (inst == 0) ? hit[1:0] : 2'b0;
    a_miss = (inst == 0) ? miss[1:0] : 2'b0;
    a_clr  = (inst == 0) ? clr : 1'b0;
    a_preq = (inst == 0) ? preq : 1'b0;
    b_rd   = (inst == 1) ? rd : 4'b0;
    b_wr   = (inst == 1) ? wr : 4'b0;
    b_hit  = (inst == 1) ? hit : 4'b0;
    b_miss = (inst == 1) ? miss : 4'b0;
    b_clr  = (inst == 1) ? clr : 1'b0;
    b_preq = (inst == 1) ? preq : 1'b0;
    @(posedge clk);
    cyc++;
    model_edge(0, {2'b0, a_rd}, {2'b0, a_wr}, {2'b0, a_hit}, {2'b0, a_miss}, a_clr, a_preq, rst_n);
    model_edge(1, b_rd, b_wr, b_hit, b_miss, b_clr, b_preq, rst_n);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic print(input int inst);
    step(inst, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic clr(input int inst);
    step(inst, 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic mon(input int i, input logic bsy, vld, input logic [63:0] h, m, r, w, pm,
                     input logic ov);
    rep_t f;
    bit   have, expv, expb;
    for (int g = 0; g < 16; g++) begin
      have = (i == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
      if (have) f = (i == 0) ? exp0[0] : exp1[0];
      if (have && f.due < cyc) begin
        chk($sformatf("missing_valid[%0d]", i), 0, 1);
        if (i == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
      end
    end
    have = (i == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
    if (have) f = (i == 0) ? exp0[0] : exp1[0];
    expv = have && (f.due == cyc);
    chk($sformatf("stats_valid[%0d]", i), {63'b0, vld}, {63'b0, expv});
    if (expv) begin
      if (i == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
      lh[i] = f.h; lm[i] = f.m; lr[i] = f.r; lw[i] = f.w; lpm[i] = f.pm;
      $display("cache_stats[%0d]: hits=%0d misses=%0d reads=%0d writes=%0d ratio=%0d.%0d%%",
               i, h, m, r, w, pm / 10, pm % 10);
    end
    chk($sformatf("tot_hits[%0d]", i), h, lh[i]);
    chk($sformatf("tot_misses[%0d]", i), m, lm[i]);
    chk($sformatf("tot_reads[%0d]", i), r, lr[i]);
    chk($sformatf("tot_writes[%0d]", i), w, lw[i]);
    chk($sformatf("hit_permille[%0d]", i), pm, lpm[i]);
    expb = (bs[i] >= 0) && (cyc >= bs[i]) && (cyc <= bs[i] + lat[i] - 1);
    chk($sformatf("busy[%0d]", i), {63'b0, bsy}, {63'b0, expb});
    chk($sformatf("ovf[%0d]", i), {63'b0, ov}, {63'b0, movf[i]});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a_busy, a_valid, 64'(a_th), 64'(a_tm), 64'(a_tr), 64'(a_tw), 64'(a_pm), a_ovf);
      mon(1, b_busy, b_valid, 64'(b_th), 64'(b_tm), 64'(b_tr), 64'(b_tw), 64'(b_pm), b_ovf);
    end
  end

  initial begin
    logic [3:0] vr, vw, vh, vm;
    nch[0] = 2; mmax[0] = 64'hFFFF_FFFF; lat[0] = 33 + 13;
    nch[1] = 4; mmax[1] = 64'hF;         lat[1] = 6 + 13;
    model_reset(0);
    model_reset(1);

    step(0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1;
    step(0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

    // zero denominator straight out of reset
    print(0);
    idle(50);

    // basic ratio: ch0 70 rd+hit, ch1 20 rd+hit, 10 wr+miss
    for (int n = 0; n < 70; n++) begin
      vr = '0; vw = '0; vh = '0; vm = '0;
      vr[CH_INS] = 1'b1; vh[CH_INS] = 1'b1;
      if (n < 20) begin vr[CH_DATA] = 1'b1; vh[CH_DATA] = 1'b1; end
      if (n < 10) begin vw[CH_DATA] = 1'b1; vm[CH_DATA] = 1'b1; end
      step(0, vr, vw, vh, vm, 1'b0, 1'b0, 1'b1);
    end
    print(0);
    idle(50);
    #1;
    chk("basic_hits", 64'(a_th), 90);
    chk("basic_misses", 64'(a_tm), 10);
    chk("basic_reads", 64'(a_tr), 90);
    chk("basic_writes", 64'(a_tw), 10);
    chk("basic_permille", 64'(a_pm), 900);

    // strobe with print_req is excluded; repeated requests while busy ignored
    clr(0);
    vh = '0; vh[CH_INS] = 1'b1;
    step(0, 4'b0, 4'b0, vh, 4'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) print(0);
    idle(50);
    #1 chk("boundary_first_hits", 64'(a_th), 0);
    print(0);
    idle(50);
    #1 chk("boundary_second_hits", 64'(a_th), 1);

    // truncation 1000/3
    clr(0);
    vr = '0; vr[CH_INS] = 1'b1;
    step(0, vr, 4'b0, vh, 4'b0, 1'b0, 1'b0, 1'b1);
    step(0, vr, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    step(0, vr, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    print(0);
    idle(50);
    #1 chk("trunc_permille", 64'(a_pm), 333);

    // reset in the middle of DIV
    print(0);
    idle(20);
    step(0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    step(0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    idle(55);
    #1;
    chk("rst_busy", {63'b0, a_busy}, 0);
    chk("rst_reads", 64'(a_tr), 0);
    chk("rst_permille", 64'(a_pm), 0);

    // random traffic
    for (int n = 0; n < 400; n++)
      step(0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 19) == 0), 1'b1);
    idle(50);

    // small instance: saturation, clear, wide sum
    clr(1);
    vh = '0; vh[CH_INS] = 1'b1;
    for (int n = 0; n < 20; n++) step(1, 4'b0, 4'b0, vh, 4'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("sat_ovf", {63'b0, b_ovf}, 1);
    print(1);
    idle(25);
    #1 chk("sat_hits", 64'(b_th), 15);
    clr(1);
    #1 chk("clr_ovf", {63'b0, b_ovf}, 0);
    print(1);
    idle(25);
    #1 chk("clr_hits", 64'(b_th), 0);
    for (int n = 0; n < 15; n++) step(1, 4'hF, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    print(1);
    idle(25);
    #1;
    chk("wide_reads", 64'(b_tr), 60);
    chk("wide_ovf", {63'b0, b_ovf}, 0);

    idle(50);
    chk("pending_reports", 64'(exp0.size() + exp1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
